// File: rtl/timer_pkg.sv
// Shared types and constants for the MM.SS timekeeping core.
//   state_e : sequencing states (IDLE, RUN, PAUSE, DONE)
//   bcd_t   : one 4-bit BCD digit
//   SEC_TENS_MAX / DIGIT_MAX : largest legal seconds-tens and BCD digit
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/timer_core_bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit that counts modulo MODULUS.
// Ports:
//   clk, rst_l     : clock, synchronous active-low reset
//   inc, dec       : step up / step down (inc wins if both)
//   clr            : force to 0 (highest priority after reset)
//   load, load_val : preset the digit
//   value          : current digit
//   carry_out      : this cycle's inc wraps MODULUS-1 -> 0
//   borrow_out     : this cycle's dec wraps 0 -> MODULUS-1
// Carry/borrow are combinational so a chain of digits steps in one cycle.
module bcd_digit_cnt
  import timer_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic clk,
  input  logic rst_l,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t value,
  output logic carry_out,
  output logic borrow_out
);

  localparam bcd_t TOP = bcd_t'(MODULUS - 1);

  always_comb begin
    carry_out  = inc & ~clr & ~load & (value == TOP);
    borrow_out = dec & ~inc & ~clr & ~load & (value == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == TOP) ? 4'd0 : value + 4'd1;
    end else if (dec) begin
      value <= (value == 4'd0) ? TOP : value - 4'd1;
    end
  end

endmodule

// File: rtl/timer_core.sv
// timer_core: 4-digit BCD MM.SS stopwatch / countdown timer feeding a
// 7-segment driver.
// Ports:
//   i_clk, i_rst_l          : clock, synchronous active-low reset
//   i_sec_tick, i_blink_tick: 1 Hz tick and blink-rate tick (1-cycle pulses)
//   i_mode                  : 0 stopwatch, 1 timer; latched when leaving IDLE
//   i_start_stop, i_clear   : button pulses
//   i_inc_min, i_inc_sec    : set pulses, honoured in IDLE only
//   i_lap                   : lap freeze toggle (only with TIMER_LAP_EN)
//   o_digit0..3             : SS ones, SS tens, MM ones, MM tens
//   o_blink, o_running, o_done : registered status to the driver
// Optional build macro: TIMER_LAP_EN adds the lap-freeze display path.
// Handshake: every input is a single-cycle pulse or level, no back-pressure;
// the effect of a pulse is visible on the outputs one clock later.
module timer_core
  import timer_pkg::*;
#(
  parameter int unsigned MAX_MIN        = 99,
  parameter int unsigned DONE_BLINK_DIV = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_l,
  input  logic       i_sec_tick,
  input  logic       i_blink_tick,
  input  logic       i_mode,
  input  logic       i_start_stop,
  input  logic       i_clear,
  input  logic       i_inc_min,
  input  logic       i_inc_sec,
`ifdef TIMER_LAP_EN
  input  logic       i_lap,
`endif
  output logic [3:0] o_digit0,
  output logic [3:0] o_digit1,
  output logic [3:0] o_digit2,
  output logic [3:0] o_digit3,
  output logic       o_blink,
  output logic       o_running,
  output logic       o_done
);

  localparam bcd_t MAX_M1  = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MAX_M0  = bcd_t'(MAX_MIN % 10);
  localparam int   BLINK_W = $clog2(DONE_BLINK_DIV + 1);

  state_e state, next_state;
  logic   mode_q;
  logic [BLINK_W-1:0] blink_cnt;

  bcd_t s0, s1, m0, m1;
  logic c0, c1, c2, b0, b1, b2;
  logic unused_c3, unused_b3;

  logic clr_all, cnt_up, cnt_down, set_min, set_sec, latch_mode;
  logic at_zero, at_one, min_at_max, at_top, almost_top, min_wrap;

  always_comb begin
    at_zero    = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd0);
    at_one     = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd1);
    min_at_max = (m1 == MAX_M1) && (m0 == MAX_M0);
    at_top     = min_at_max && (s1 == SEC_TENS_MAX) && (s0 == DIGIT_MAX);
    almost_top = min_at_max && (s1 == SEC_TENS_MAX) && (s0 == DIGIT_MAX - 4'd1);
    min_wrap   = set_min && min_at_max;
  end

  // Next-state and per-cycle counter controls. i_clear outranks everything,
  // then i_start_stop, then i_sec_tick; set pulses only act in IDLE and only
  // when no start/stop pulse is present.
  always_comb begin
    next_state = state;
    clr_all    = 1'b0;
    cnt_up     = 1'b0;
    cnt_down   = 1'b0;
    set_min    = 1'b0;
    set_sec    = 1'b0;
    latch_mode = 1'b0;
    if (i_clear) begin
      next_state = IDLE;
      clr_all    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_start_stop) begin
            // A timer cannot start from 00.00.
            if (!(i_mode && at_zero)) begin
              next_state = RUN;
              latch_mode = 1'b1;
            end
          end else begin
            set_min = i_inc_min;
            set_sec = i_inc_sec;
          end
        end
        RUN: begin
          if (i_start_stop) begin
            next_state = PAUSE;
          end else if (i_sec_tick) begin
            if (!mode_q) begin
              if (at_top) begin
                next_state = DONE;
              end else begin
                cnt_up = 1'b1;
                if (almost_top) next_state = DONE;
              end
            end else begin
              if (at_zero) begin
                next_state = DONE;
              end else begin
                cnt_down = 1'b1;
                if (at_one) next_state = DONE;
              end
            end
          end
        end
        PAUSE: begin
          if (i_start_stop) next_state = RUN;
        end
        DONE: begin
          if (i_start_stop) begin
            next_state = IDLE;
            clr_all    = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_l) state <= IDLE;
    else          state <= next_state;
  end

  // Status flops are loaded from next_state so they line up with the digits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      mode_q    <= 1'b0;
      blink_cnt <= '0;
      o_blink   <= 1'b0;
      o_running <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      if (latch_mode) mode_q <= i_mode;
      o_running <= (next_state == RUN);
      o_done    <= (next_state == DONE);
      if ((state != DONE) || (next_state != DONE)) begin
        // Entering, leaving or outside DONE: blink restarts from 0.
        blink_cnt <= '0;
        o_blink   <= 1'b0;
      end else if (i_blink_tick) begin
        if (blink_cnt == BLINK_W'(DONE_BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          o_blink   <= ~o_blink;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // Digit chain. Seconds-tens carry is only forwarded while running, so
  // setting seconds wraps 59 -> 00 without touching the minutes.
  bcd_digit_cnt #(.MODULUS(10)) u_sec_ones (
    .clk(i_clk), .rst_l(i_rst_l),
    .inc(cnt_up | set_sec), .dec(cnt_down), .clr(clr_all),
    .load(1'b0), .load_val(4'd0),
    .value(s0), .carry_out(c0), .borrow_out(b0)
  );

  bcd_digit_cnt #(.MODULUS(6)) u_sec_tens (
    .clk(i_clk), .rst_l(i_rst_l),
    .inc(c0), .dec(b0), .clr(clr_all),
    .load(1'b0), .load_val(4'd0),
    .value(s1), .carry_out(c1), .borrow_out(b1)
  );

  bcd_digit_cnt #(.MODULUS(10)) u_min_ones (
    .clk(i_clk), .rst_l(i_rst_l),
    .inc((cnt_up & c1) | (set_min & ~min_at_max)), .dec(b1),
    .clr(clr_all | min_wrap),
    .load(1'b0), .load_val(4'd0),
    .value(m0), .carry_out(c2), .borrow_out(b2)
  );

  bcd_digit_cnt #(.MODULUS(10)) u_min_tens (
    .clk(i_clk), .rst_l(i_rst_l),
    .inc(c2), .dec(b2), .clr(clr_all | min_wrap),
    .load(1'b0), .load_val(4'd0),
    .value(m1), .carry_out(unused_c3), .borrow_out(unused_b3)
  );

`ifdef TIMER_LAP_EN
  logic        lap_q;
  logic [15:0] snap_q;

  // Lap toggles only in RUN; the count keeps running underneath the snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      lap_q  <= 1'b0;
      snap_q <= 16'h0000;
    end else if (clr_all || (next_state == DONE)) begin
      lap_q <= 1'b0;
    end else if ((state == RUN) && i_lap) begin
      lap_q <= ~lap_q;
      if (!lap_q) snap_q <= {m1, m0, s1, s0};
    end
  end

  always_comb begin
    {o_digit3, o_digit2, o_digit1, o_digit0} = lap_q ? snap_q : {m1, m0, s1, s0};
  end
`else
  always_comb begin
    {o_digit3, o_digit2, o_digit1, o_digit0} = {m1, m0, s1, s0};
  end
`endif

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core (MAX_MIN=11, DONE_BLINK_DIV=2). A reference model
// keeps the time as plain integer minutes/seconds and is compared with the
// DUT after every clock; directed sequences add fixed-value checks.
module tb_timer_core;

  localparam int MAX_MIN = 11;
  localparam int DIV     = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l = 1'b0;
  logic tick = 0, btick = 0, mode = 0, ss = 0, clr = 0, im = 0, is = 0;
  logic [3:0] d0, d1, d2, d3;
  logic blink, running, done;
`ifdef TIMER_LAP_EN
  logic lap = 1'b0;
`endif

  timer_core #(.MAX_MIN(MAX_MIN), .DONE_BLINK_DIV(DIV)) dut (
    .i_clk(clk), .i_rst_l(rst_l), .i_sec_tick(tick), .i_blink_tick(btick),
    .i_mode(mode), .i_start_stop(ss), .i_clear(clr),
    .i_inc_min(im), .i_inc_sec(is),
`ifdef TIMER_LAP_EN
    .i_lap(lap),
`endif
    .o_digit0(d0), .o_digit1(d1), .o_digit2(d2), .o_digit3(d3),
    .o_blink(blink), .o_running(running), .o_done(done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int m_st = S_IDLE, m_min = 0, m_sec = 0, m_mode = 0, m_blink = 0, m_bcnt = 0;

  function automatic logic [15:0] exp_digits();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  task automatic enter_done();
    m_st = S_DONE; m_blink = 0; m_bcnt = 0;
  endtask

  task automatic go_idle_zero();
    m_st = S_IDLE; m_min = 0; m_sec = 0; m_blink = 0; m_bcnt = 0;
  endtask

  task automatic model_step();
    int t;
    int top;
    top = MAX_MIN * 60 + 59;
    if (!rst_l) begin
      go_idle_zero();
      m_mode = 0;
      return;
    end
    if (clr) begin
      go_idle_zero();
      return;
    end
    t = m_min * 60 + m_sec;
    case (m_st)
      S_IDLE: begin
        if (ss) begin
          if (!(mode && t == 0)) begin
            m_mode = int'(mode);
            m_st = S_RUN;
          end
        end else begin
          if (im) m_min = (m_min + 1) % (MAX_MIN + 1);
          if (is) m_sec = (m_sec + 1) % 60;
        end
      end
      S_RUN: begin
        if (ss) m_st = S_PAUSE;
        else if (tick) begin
          if (m_mode == 0) begin
            if (t < top) t++;
            if (t == top) enter_done();
          end else begin
            if (t > 0) t--;
            if (t == 0) enter_done();
          end
          m_min = t / 60;
          m_sec = t % 60;
        end
      end
      S_PAUSE: if (ss) m_st = S_RUN;
      default: begin
        if (ss) go_idle_zero();
        else if (btick) begin
          m_bcnt++;
          if (m_bcnt == DIV) begin
            m_bcnt = 0;
            m_blink ^= 1;
          end
        end
      end
    endcase
  endtask

  // driver tasks
  task automatic drive(input logic p_ss, input logic p_clr, input logic p_im,
                       input logic p_is, input logic p_tick, input logic p_btick);
    ss = p_ss; clr = p_clr; im = p_im; is = p_is; tick = p_tick; btick = p_btick;
  endtask

  // One clock: model follows the same inputs, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    drive(0, 0, 0, 0, 0, 0);
    check("digits", {d3, d2, d1, d0}, exp_digits());
    check("running", 16'(running), 16'(m_st == S_RUN));
    check("done", 16'(done), 16'(m_st == S_DONE));
    check("blink", 16'(blink), 16'(m_blink));
  endtask

  task automatic pulse(input logic p_ss, input logic p_clr, input logic p_im,
                       input logic p_is, input logic p_tick, input logic p_btick);
    drive(p_ss, p_clr, p_im, p_is, p_tick, p_btick);
    step();
  endtask

  initial begin
    // reset with inputs toggling
    rst_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = 1'($urandom_range(0, 1));
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    check("rst_digits", {d3, d2, d1, d0}, 16'h0000);
    check("rst_blink", 16'(blink), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_running", 16'(running), 16'h0);
    rst_l = 1'b1;
    mode  = 1'b0;
    step();

    // timer 00.03 down to done, then blink
    mode = 1'b1;
    repeat (3) pulse(0, 0, 0, 1, 0, 0);
    check("t_set", {d3, d2, d1, d0}, 16'h0003);
    pulse(1, 0, 0, 0, 0, 0);
    check("t_run", 16'(running), 16'h1);
    pulse(0, 0, 0, 0, 1, 0);
    check("t_2", {d3, d2, d1, d0}, 16'h0002);
    pulse(0, 0, 0, 0, 1, 0);
    check("t_1", {d3, d2, d1, d0}, 16'h0001);
    check("t_not_done", 16'(done), 16'h0);
    pulse(0, 0, 0, 0, 1, 0);
    check("t_0", {d3, d2, d1, d0}, 16'h0000);
    check("t_done", 16'(done), 16'h1);
    check("t_blink0", 16'(blink), 16'h0);
    pulse(0, 0, 0, 0, 0, 1);
    check("t_blink1", 16'(blink), 16'h0);
    pulse(0, 0, 0, 0, 0, 1);
    check("t_blink2", 16'(blink), 16'h1);
    pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 0, 1);
    check("t_blink4", 16'(blink), 16'h0);
    pulse(1, 0, 0, 0, 0, 0);
    check("t_exit", {d3, d2, d1, d0, 3'b0, done, blink, running, 8'h0}, 16'h0000);

    // timer 01.00 borrow, pause, resume
    pulse(0, 0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("borrow", {d3, d2, d1, d0}, 16'h0059);
    pulse(1, 0, 0, 0, 0, 0);
    repeat (5) pulse(0, 0, 0, 0, 1, 0);
    check("pause_hold", {d3, d2, d1, d0}, 16'h0059);
    check("pause_run", 16'(running), 16'h0);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("resume", {d3, d2, d1, d0}, 16'h0058);
    pulse(0, 1, 0, 0, 0, 0);

    // minute wrap and second wrap while setting
    repeat (MAX_MIN) pulse(0, 0, 1, 0, 0, 0);
    check("min_max", {d3, d2, d1, d0}, 16'h1100);
    pulse(0, 0, 1, 0, 0, 0);
    check("min_wrap", {d3, d2, d1, d0}, 16'h0000);
    repeat (60) pulse(0, 0, 0, 1, 0, 0);
    check("sec_wrap", {d3, d2, d1, d0}, 16'h0000);

    // stopwatch 10.00 -> 11.59 saturates
    mode = 1'b0;
    repeat (10) pulse(0, 0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    repeat (119) pulse(0, 0, 0, 0, 1, 0);
    check("sw_top", {d3, d2, d1, d0}, 16'h1159);
    check("sw_done", 16'(done), 16'h1);
    repeat (3) pulse(0, 0, 0, 0, 1, 0);
    check("sw_hold", {d3, d2, d1, d0}, 16'h1159);
    pulse(0, 1, 0, 0, 0, 0);

    // same-cycle priority in RUN
    mode = 1'b1;
    repeat (5) pulse(0, 0, 0, 1, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(1, 1, 0, 0, 0, 0);
    check("clr_ss", {d3, d2, d1, d0, 7'b0, running, 8'h0}, 16'h0000);
    repeat (5) pulse(0, 0, 0, 1, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    pulse(1, 0, 0, 0, 1, 0);
    check("ss_tick", {d3, d2, d1, d0}, 16'h0004);
    check("ss_tick_run", 16'(running), 16'h0);
    pulse(0, 1, 0, 0, 0, 0);

    // timer start at 00.00 is ignored
    pulse(1, 0, 0, 0, 0, 0);
    check("zero_start", 16'(running), 16'h0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 49);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      drive(r <= 4, r == 0, (r >= 5 && r <= 10) || r == 15, r >= 11 && r <= 16,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
